// File: rtl/vga_scan_ctrl_if.sv
// Bundle of the scan controller's bus signals: video outputs, the writer
// request/grant port and the framebuffer RAM port.
// The slave modport is the scan controller; the master modport is the
// surrounding system (writer, RAM and display sink).
interface vga_scan_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int AW     = 19
);
    // video outputs
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [DATA_W-1:0] pixel;
    logic              frame_start;

    // writer port
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_err;

    // framebuffer RAM port
    logic [AW-1:0]     fb_addr;
    logic              fb_re;
    logic              fb_we;
    logic [DATA_W-1:0] fb_wdata;
    logic [DATA_W-1:0] fb_rdata;

    modport slave (
        output hsync, vsync, de, pixel, frame_start,
        input  wr_req, wr_addr, wr_data,
        output wr_ack, wr_err,
        output fb_addr, fb_re, fb_we, fb_wdata,
        input  fb_rdata
    );

    modport master (
        input  hsync, vsync, de, pixel, frame_start,
        output wr_req, wr_addr, wr_data,
        input  wr_ack, wr_err,
        input  fb_addr, fb_re, fb_we, fb_wdata,
        output fb_rdata
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: free-running raster counters, display read of a
// single-port framebuffer with writer access granted only in blanking, and a
// 3-cycle aligned video output pipeline.
module vga_scan_ctrl #(
    parameter int H_SYNCPULSE = 96,
    parameter int H_BPORCH    = 48,
    parameter int H_DISPLAY   = 640,
    parameter int H_FPORCH    = 16,
    parameter int H_SYNC      = 800,
    parameter int V_SYNCPULSE = 2,
    parameter int V_BPORCH    = 33,
    parameter int V_DISPLAY   = 480,
    parameter int V_FPORCH    = 10,
    parameter int V_SYNC      = 525,
    parameter int DATA_W      = 8,
    parameter int AW          = 19
) (
    input logic            clk,
    input logic            rst,
    vga_scan_ctrl_if.slave bus
);
    localparam int HW = $clog2(H_SYNC + 1);
    localparam int VW = $clog2(V_SYNC + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_SYNC - 1);
    localparam logic [HW-1:0] H_SP   = HW'(H_SYNCPULSE);
    localparam logic [HW-1:0] H_AS   = HW'(H_SYNCPULSE + H_BPORCH);
    // The active window ends where the front porch begins, which for a
    // consistent timing set is H_SYNCPULSE + H_BPORCH + H_DISPLAY.
    localparam logic [HW-1:0] H_AE   = HW'(H_SYNC - H_FPORCH);
    localparam logic [VW-1:0] V_LAST = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] V_SP   = VW'(V_SYNCPULSE);
    localparam logic [VW-1:0] V_AS   = VW'(V_SYNCPULSE + V_BPORCH);
    localparam logic [VW-1:0] V_AE   = VW'(V_SYNC - V_FPORCH);
    // One extra bit so a full 2**AW framebuffer still compares correctly.
    localparam logic [AW:0]   NPIX   = (AW + 1)'(H_DISPLAY * V_DISPLAY);

    typedef enum logic [1:0] {
        DISP,
        IDLE,
        WR
    } arb_state_t;

    logic [HW-1:0]     hc;
    logic [VW-1:0]     vc;
    logic [AW-1:0]     pix;
    logic              hs;
    logic              vs;
    logic              act;
    logic              first;
    logic [3:0]        tm_d1;
    logic [3:0]        tm_d2;
    logic              hsync_reg;
    logic              vsync_reg;
    logic              de_reg;
    logic              frame_start_reg;
    logic [DATA_W-1:0] pixel_reg;
    arb_state_t        state;
    logic              ack_block;
    logic [AW-1:0]     fb_addr_reg;
    logic              fb_re_reg;
    logic              fb_we_reg;
    logic [DATA_W-1:0] fb_wdata_reg;
    logic              wr_ack_reg;
    logic              wr_err_reg;

    // Raw timing decoded from the counters.
    assign hs    = (hc < H_SP);
    assign vs    = (vc < V_SP);
    assign act   = (hc >= H_AS) && (hc < H_AE) && (vc >= V_AS) && (vc < V_AE);
    assign first = (hc == '0) && (vc == '0);

    // A request granted last cycle (or rejected last cycle) is still visible
    // to the writer as an ack this cycle, so it must not be granted again.
    assign ack_block = (state == WR) || wr_err_reg;

    // Horizontal and vertical raster counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
        end else begin
            hc <= hc + HW'(1);
        end
    end

    // Running linear pixel index; advances once per active cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix <= '0;
        end else if (first) begin
            pix <= '0;
        end else if (act) begin
            pix <= pix + AW'(1);
        end
    end

    // Delay timing by two stages to line up with the RAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tm_d1 <= '0;
            tm_d2 <= '0;
        end else begin
            tm_d1 <= {first, act, vs, hs};
            tm_d2 <= tm_d1;
        end
    end

    // Output register stage: sync, enable and pixel leave together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            de_reg          <= 1'b0;
            frame_start_reg <= 1'b0;
            pixel_reg       <= '0;
        end else begin
            hsync_reg       <= tm_d2[0];
            vsync_reg       <= tm_d2[1];
            de_reg          <= tm_d2[2];
            frame_start_reg <= tm_d2[3];
            pixel_reg       <= tm_d2[2] ? bus.fb_rdata : '0;
        end
    end

    // Port arbiter: display reads own every active cycle, writer gets the
    // port in blanking; all port controls are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            fb_addr_reg  <= '0;
            fb_re_reg    <= 1'b0;
            fb_we_reg    <= 1'b0;
            fb_wdata_reg <= '0;
            wr_ack_reg   <= 1'b0;
            wr_err_reg   <= 1'b0;
        end else begin
            fb_re_reg  <= 1'b0;
            fb_we_reg  <= 1'b0;
            wr_ack_reg <= 1'b0;
            wr_err_reg <= 1'b0;
            if (act) begin
                state       <= DISP;
                fb_re_reg   <= 1'b1;
                fb_addr_reg <= pix;
            end else if (bus.wr_req && !ack_block) begin
                wr_ack_reg <= 1'b1;
                if ({1'b0, bus.wr_addr} < NPIX) begin
                    state        <= WR;
                    fb_we_reg    <= 1'b1;
                    fb_addr_reg  <= bus.wr_addr;
                    fb_wdata_reg <= bus.wr_data;
                end else begin
                    state      <= IDLE;
                    wr_err_reg <= 1'b1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

    assign bus.hsync       = hsync_reg;
    assign bus.vsync       = vsync_reg;
    assign bus.de          = de_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.pixel       = pixel_reg;
    assign bus.fb_addr     = fb_addr_reg;
    assign bus.fb_re       = fb_re_reg;
    assign bus.fb_we       = fb_we_reg;
    assign bus.fb_wdata    = fb_wdata_reg;
    assign bus.wr_ack      = wr_ack_reg;
    assign bus.wr_err      = wr_err_reg;
endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Parameter H_SYNCPULSE, default 96, horizontal sync pulse length in clk cycles.
REQ-002 Parameter H_BPORCH, default 48; H_DISPLAY, default 640; H_FPORCH, default 16; H_SYNC, default 800, horizontal total.
REQ-003 Parameter V_SYNCPULSE, default 2; V_BPORCH, default 33; V_DISPLAY, default 480; V_FPORCH, default 10; V_SYNC, default 525, vertical total in lines.
REQ-004 Parameter DATA_W, default 8, pixel width; AW, default 19, framebuffer address width.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, pixel clock; all logic on posedge clk. rst input 1, asynchronous active-high reset.
REQ-006 Frame outputs: hsync output 1 (high during pulse); vsync output 1 (high during pulse); de output 1 (high = active pixel); pixel output DATA_W (displayed pixel, 0 outside active region); frame_start output 1 (one-cycle pulse).
REQ-007 Writer port: wr_req input 1; wr_addr input AW; wr_data input DATA_W; wr_ack output 1, one-cycle grant pulse; wr_err output 1, one-cycle pulse on out-of-range address.
REQ-008 Framebuffer port (single-port synchronous RAM, 1-cycle read latency): fb_addr output AW; fb_re output 1; fb_we output 1; fb_wdata output DATA_W; fb_rdata input DATA_W.

Function
REQ-009 hc counts 0..H_SYNC-1, wrapping to 0; vc increments on each hc wrap, counting 0..V_SYNC-1 and wrapping to 0.
REQ-010 Raw timing at counter stage: hs = (hc < H_SYNCPULSE); vs = (vc < V_SYNCPULSE); act = hc in [H_SYNCPULSE+H_BPORCH, H_SYNCPULSE+H_BPORCH+H_DISPLAY) and vc in [V_SYNCPULSE+V_BPORCH, V_SYNCPULSE+V_BPORCH+V_DISPLAY).
REQ-011 Linear pixel index pix = (vc - V first active line)*H_DISPLAY + (hc - H first active column), kept as an AW-bit running counter: cleared when hc=0 and vc=0, incremented once per act cycle; never a multiplier.
REQ-012 Arbiter FSM states: DISP (act=1, display owns port), IDLE (act=0, no write pending), WR (act=0, write issued this cycle); next state evaluated every cycle from act and wr_req.
REQ-013 In an act cycle t: fb_re=1, fb_we=0, fb_addr=pix, all registered (visible cycle t+1); a pending wr_req is not granted.
REQ-014 In a non-act cycle with wr_req=1 and wr_addr < H_DISPLAY*V_DISPLAY: state WR; at t+1 fb_we=1, fb_re=0, fb_addr=wr_addr, fb_wdata=wr_data, wr_ack=1 for exactly one cycle.
REQ-015 Non-act cycle with wr_req=1 and wr_addr >= H_DISPLAY*V_DISPLAY: wr_ack=1 and wr_err=1 for one cycle at t+1, fb_we=0, no memory access.
REQ-016 Writer SHALL hold wr_req/wr_addr/wr_data stable until wr_ack; block SHALL not issue two acks for one request: after an ack, a request still high in the ack cycle is treated as new and granted no earlier than the following cycle.
REQ-017 Otherwise fb_re=0, fb_we=0, fb_addr holds its last value.
REQ-018 hs, vs, act SHALL be delayed 3 cycles; hsync, vsync, de registered outputs aligned with pixel; pixel = fb_rdata registered when delayed act=1, else 0. Total counter-to-output latency 3 cycles.
REQ-019 frame_start pulses one cycle when the delayed counter pair equals (0,0), i.e. 3 cycles after hc=vc=0.
REQ-020 Boundary: last active pixel of a line and first blank cycle are adjacent; a write may be granted in the first non-act cycle; display read is never delayed or dropped.

Reset
REQ-021 While rst=1: hc=0, vc=0, pix=0, state IDLE, pipelines cleared; hsync, vsync, de, frame_start, wr_ack, wr_err, fb_re, fb_we = 0; pixel, fb_addr, fb_wdata = 0.
REQ-022 Reset mid-request: pending request is discarded without ack; writer retries by holding wr_req; after release, counting resumes from hc=0, vc=0 on the first posedge.

Verification
REQ-023 Free-run 2 frames after reset: hsync high 96 of every 800 cycles, vsync high 2 of 525 lines, de high 640x480 cycles per frame, frame_start period 420000 cycles.
REQ-024 RAM model returning fb_rdata = addr[7:0]: first de cycle of each line n shows pixel = (n*640)[7:0], increasing by 1 per cycle across the line.
REQ-025 wr_req held from mid-active line with wr_addr=1234, wr_data=8'hA5: no ack until first blank cycle; then fb_we=1, fb_addr=1234, wr_ack one cycle; readback of pixel 1234 next frame is 8'hA5.
REQ-026 wr_addr=307200 in blanking -> wr_ack=1, wr_err=1, fb_we stays 0.
REQ-027 Back-to-back writes (req held, address changed after each ack) during horizontal blanking -> at most one ack per 2 cycles, none during act, fb_re continuous over the 640 active cycles.
REQ-028 rst asserted for 1 cycle mid-line with wr_req pending -> all outputs 0 asynchronously, no wr_ack; hsync rises 3 cycles after release.
